controle_es: RTL and testbench
==============================

// Module: controle_es
// PURPOSE
// I/O handshake controller between the board inputs and the CPU. Replaces gating the
// CPU clock with a single clock plus a CPU clock-enable. Debounces the step button,
// stalls the CPU on IN/OUT until the user presses the button, and terminates on HALT.
// Also latches the switch input word and the display word for the output module.
// PARAMETERS
// W_IN        18          switch / input data width
// W_DISP      28          display data width
// DEB_CYCLES  16          consecutive stable cycles required to accept a button level
// BLANK       {W_DISP{1}} value driven on disp_out when no OUT is pending
// AUTO_CYCLES 1024        WAIT_OUT auto-resume delay (CONTROLE_ES_AUTO_EN only)
// PORTS
// clock      in   1       system clock
// reset      in   1       synchronous reset, active-high
// button_in  in   1       raw step button, asynchronous, active-high
// switches   in   W_IN    raw switch word, asynchronous
// OpIn       in   1       CPU decodes IN in the current cycle
// OpOut      in   1       CPU decodes OUT in the current cycle
// OpHalt     in   1       CPU decodes HALT in the current cycle
// display_in in   W_DISP  CPU output word, valid while OpOut=1
// cpu_en     out  1       CPU clock-enable; CPU state advances only when 1
// in_data    out  W_IN    registered switch word presented to the CPU
// disp_out   out  W_DISP  registered display word for the output module
// status     out  4       {halt, wait_out, wait_in, run}, one-hot state
// BEHAVIOUR
// - Reset values: state=RUN, status=4'b0001, in_data=0, disp_out=BLANK,
//   debounce counter=0, debounced level=0, sync FFs=0. cpu_en follows the RUN rule below.
// - button_in and switches each pass through a 2-FF synchronizer.
// - Debounce: the counter increments while the sync level differs from the debounced
//   level and clears otherwise. When it reaches DEB_CYCLES-1, the debounced level
//   toggles and the counter clears.
// - press: 1-cycle pulse on a 0->1 transition of the debounced level. Latency from a
//   stable raw edge is 2 + DEB_CYCLES + 1 cycles.
// - FSM states: RUN, WAIT_IN, WAIT_OUT, HALT.
//   RUN:
//     cpu_en = ~(OpIn|OpOut|OpHalt), combinational.
//     Priority is OpHalt > OpIn > OpOut.
//     OpHalt -> HALT.
//     OpIn -> WAIT_IN.
//     OpOut -> WAIT_OUT, and disp_out <= display_in on that edge.
//     press is ignored.
//   WAIT_IN:
//     in_data <= switches_sync every cycle except the press cycle (held stable).
//     cpu_en = press.
//     press -> RUN.
//   WAIT_OUT:
//     cpu_en = press.
//     press -> RUN, and disp_out <= BLANK on the same edge.
//   HALT: cpu_en=0 and terminal; only reset exits. press is ignored.
// - After a press pulse the CPU advances exactly one instruction. The next cycle is
//   in RUN, so a back-to-back IN or OUT stalls again immediately.
// - A press that arrives during a RUN stall cycle (OpIn seen, state not yet WAIT_IN)
//   is dropped. The user must press again.
// - Reset mid-wait: the FSM returns to RUN, disp_out returns to BLANK, and the
//   debounce logic restarts. A held button does not produce a press until it is
//   released and pressed again.
// - Widths are fixed. No arithmetic on data; the counters saturate-free and wrap only
//   via the clear rules above.
// CONFIGURATION
// - CONTROLE_ES_AUTO_EN defined:
//   - A counter runs in WAIT_OUT.
//   - After AUTO_CYCLES cycles without a press, cpu_en=1 for 1 cycle and the FSM goes
//     to RUN exactly as for a press.
//   - A press still resumes early.
//   - The counter clears on WAIT_OUT entry and on reset.
// - CONTROLE_ES_AUTO_EN undefined: the counter logic is absent; WAIT_OUT waits
//   indefinitely for a press.
// - WAIT_IN always requires a press.
// TESTING (DEB_CYCLES=4, AUTO_CYCLES=8)
// - reset held 3 cycles, no ops -> status=0001, cpu_en=1, disp_out=BLANK, in_data=0.
// - OpIn=1, switches=18'h2A5A5 held, press 12 cycles ->
//   - cpu_en=0 until the press pulse, then exactly 1 cycle high.
//   - in_data=18'h2A5A5 at the pulse; next status=0001.
// - OpOut=1, display_in=28'h0123456 ->
//   - disp_out=28'h0123456 with status=0100.
//   - after press: 1 cpu_en pulse, then disp_out=BLANK.
// - button bounce 1-0-1-0 with 2-cycle glitches, then held high 10 cycles ->
//   exactly one press pulse, exactly one cpu_en pulse.
// - OpHalt=1 and OpIn=1 in the same cycle -> HALT (status=1000); later presses leave
//   cpu_en=0; reset -> RUN.
// - AUTO_EN defined, OpOut, no press -> cpu_en pulse after 8 WAIT_OUT cycles.
//   Undefined -> cpu_en stays 0 for 100 cycles.

Source files
------------

// File: rtl/controle_es.sv
// ----------------------------------------------------------------------------
// controle_es
//
// Sits between the board I/O and the CPU. The CPU shares the single system
// clock and only advances when cpu_en is high. An IN or OUT instruction
// stalls the CPU until the user presses the step button. A HALT instruction
// stops the CPU for good, until reset. The block also owns the registered
// switch word given to the CPU and the registered word sent to the display.
//
// Optional feature macro: CONTROLE_ES_AUTO_EN
//   When defined, a WAIT_OUT stall resumes by itself after AUTO_CYCLES
//   cycles, or earlier if the button is pressed.
//   When undefined, WAIT_OUT waits for a press with no time limit.
//
// Ports
//   clock       in   1       system clock
//   reset       in   1       synchronous reset, active-high
//   button_in   in   1       raw step button, asynchronous, active-high
//   switches    in   W_IN    raw switch word, asynchronous
//   OpIn        in   1       CPU decodes IN in the current cycle
//   OpOut       in   1       CPU decodes OUT in the current cycle
//   OpHalt      in   1       CPU decodes HALT in the current cycle
//   display_in  in   W_DISP  CPU output word, valid while OpOut=1
//   cpu_en      out  1       CPU clock-enable
//   in_data     out  W_IN    registered switch word for the CPU
//   disp_out    out  W_DISP  registered display word
//   status      out  4       {halt, wait_out, wait_in, run}, one-hot
//
// FSM states
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   RUN       | CPU runs; an IN/OUT/HALT decode holds it and picks a stall
//   WAIT_IN   | in_data follows the switches; a press lets IN complete
//   WAIT_OUT  | disp_out shows the OUT word; a press (or timeout) resumes
//   HALT      | CPU stopped; only reset leaves this state
// ----------------------------------------------------------------------------
module controle_es #(
  parameter int unsigned       W_IN       = 18,
  parameter int unsigned       W_DISP     = 28,
  parameter int unsigned       DEB_CYCLES = 16,
  parameter logic [W_DISP-1:0] BLANK      = {W_DISP{1'b1}}
`ifdef CONTROLE_ES_AUTO_EN
  ,
  parameter int unsigned       AUTO_CYCLES = 1024
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              button_in,
  input  logic [W_IN-1:0]   switches,
  input  logic              OpIn,
  input  logic              OpOut,
  input  logic              OpHalt,
  input  logic [W_DISP-1:0] display_in,
  output logic              cpu_en,
  output logic [W_IN-1:0]   in_data,
  output logic [W_DISP-1:0] disp_out,
  output logic [3:0]        status
);

  localparam int unsigned   DW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);

`ifdef CONTROLE_ES_AUTO_EN
  localparam int unsigned   AW        = $clog2(AUTO_CYCLES + 1);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_CYCLES);
  localparam logic [AW-1:0] AUTO_ONE  = AW'(1);
`endif

  // One-hot encoding so status is the state register itself.
  typedef enum logic [3:0] {
    ST_RUN      = 4'b0001,
    ST_WAIT_IN  = 4'b0010,
    ST_WAIT_OUT = 4'b0100,
    ST_HALT     = 4'b1000
  } state_t;

  // Synchronizers
  logic [1:0]        btn_sync_q;
  logic [W_IN-1:0]   sw_meta_q;
  logic [W_IN-1:0]   sw_sync_q;
  // Marks the synchronizer output as real data rather than its reset value.
  logic [1:0]        sync_fill_q;

  // Debouncer
  logic [DW-1:0]     deb_cnt_q, deb_cnt_d;
  logic              deb_level_q, deb_level_d;
  logic              deb_prev_q;
  logic              deb_differs;
  logic              armed_q, armed_d;
  logic              press_q, press_d;

  // Controller
  state_t            state_q, state_d;
  logic [W_IN-1:0]   in_data_q, in_data_d;
  logic [W_DISP-1:0] disp_q, disp_d;
  logic              out_resume;

`ifdef CONTROLE_ES_AUTO_EN
  logic [AW-1:0]     auto_cnt_q, auto_cnt_d;
`endif

  // --------------------------------------------------------------------------
  // Debounce and press detection
  // --------------------------------------------------------------------------
  always_comb begin
    deb_differs = btn_sync_q[1] ^ deb_level_q;
    deb_cnt_d   = '0;
    deb_level_d = deb_level_q;
    if (deb_differs) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_level_d = ~deb_level_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_ONE;
      end
    end

    // A button that is already held when reset ends must not count as a
    // press. Presses are only accepted once the button has been seen
    // released, with the debounced level low, after reset.
    armed_d = armed_q | (sync_fill_q[1] & ~btn_sync_q[1] & ~deb_level_q);

    // Registered one-cycle pulse on the rising edge of the debounced level.
    press_d = deb_level_q & ~deb_prev_q & armed_q;
  end

  // --------------------------------------------------------------------------
  // Control FSM, next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cpu_en     = 1'b0;
    in_data_d  = in_data_q;
    disp_d     = disp_q;
    out_resume = press_q;
`ifdef CONTROLE_ES_AUTO_EN
    auto_cnt_d = auto_cnt_q;
`endif

    unique case (state_q)
      ST_RUN: begin
        // The CPU must not advance past an I/O or HALT decode on its own.
        cpu_en = ~(OpIn | OpOut | OpHalt);
        if (OpHalt) begin
          state_d = ST_HALT;
        end else if (OpIn) begin
          state_d = ST_WAIT_IN;
        end else if (OpOut) begin
          state_d = ST_WAIT_OUT;
          disp_d  = display_in;
`ifdef CONTROLE_ES_AUTO_EN
          auto_cnt_d = '0;
`endif
        end
      end

      ST_WAIT_IN: begin
        cpu_en = press_q;
        if (press_q) begin
          // in_data is frozen in the cycle the CPU consumes it.
          state_d = ST_RUN;
        end else begin
          in_data_d = sw_sync_q;
        end
      end

      ST_WAIT_OUT: begin
`ifdef CONTROLE_ES_AUTO_EN
        out_resume = press_q | (auto_cnt_q == AUTO_LAST);
        if (!out_resume) begin
          auto_cnt_d = auto_cnt_q + AUTO_ONE;
        end
`endif
        cpu_en = out_resume;
        if (out_resume) begin
          state_d = ST_RUN;
          disp_d  = BLANK;
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_sync_q  <= '0;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      sync_fill_q <= '0;
      deb_cnt_q   <= '0;
      deb_level_q <= 1'b0;
      deb_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
      press_q     <= 1'b0;
      state_q     <= ST_RUN;
      in_data_q   <= '0;
      disp_q      <= BLANK;
`ifdef CONTROLE_ES_AUTO_EN
      auto_cnt_q  <= '0;
`endif
    end else begin
      btn_sync_q  <= {btn_sync_q[0], button_in};
      sw_meta_q   <= switches;
      sw_sync_q   <= sw_meta_q;
      sync_fill_q <= {sync_fill_q[0], 1'b1};
      deb_cnt_q   <= deb_cnt_d;
      deb_level_q <= deb_level_d;
      deb_prev_q  <= deb_level_q;
      armed_q     <= armed_d;
      press_q     <= press_d;
      state_q     <= state_d;
      in_data_q   <= in_data_d;
      disp_q      <= disp_d;
`ifdef CONTROLE_ES_AUTO_EN
      auto_cnt_q  <= auto_cnt_d;
`endif
    end
  end

  assign in_data  = in_data_q;
  assign disp_out = disp_q;
  assign status   = state_q;

endmodule

// File: tb/tb_controle_es.sv
// ----------------------------------------------------------------------------
// tb_controle_es
//
// Directed bench for controle_es with DEB_CYCLES=4 (and AUTO_CYCLES=8 when
// CONTROLE_ES_AUTO_EN is defined). Inputs change 1 ns after the rising edge;
// outputs are sampled there too, after combinational settling.
// ----------------------------------------------------------------------------
module tb_controle_es;

  localparam int unsigned W_IN   = 18;
  localparam int unsigned W_DISP = 28;
  localparam logic [31:0] BLANK  = 32'h0FFF_FFFF;

  localparam logic [31:0] S_RUN  = 32'h1;
  localparam logic [31:0] S_WIN  = 32'h2;
  localparam logic [31:0] S_WOUT = 32'h4;
  localparam logic [31:0] S_HALT = 32'h8;

  logic              clock = 1'b0;
  logic              reset;
  logic              button_in;
  logic [W_IN-1:0]   switches;
  logic              OpIn, OpOut, OpHalt;
  logic [W_DISP-1:0] display_in;
  logic              cpu_en;
  logic [W_IN-1:0]   in_data;
  logic [W_DISP-1:0] disp_out;
  logic [3:0]        status;

  int n_checks = 0;
  int n_fail   = 0;

  int          pulses;
  int          first_idx;
  logic [31:0] in_at;
  logic [31:0] disp_at;

  always #5 clock = ~clock;

  controle_es #(
    .W_IN       (W_IN),
    .W_DISP     (W_DISP),
    .DEB_CYCLES (4)
`ifdef CONTROLE_ES_AUTO_EN
    ,
    .AUTO_CYCLES(8)
`endif
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .button_in  (button_in),
    .switches   (switches),
    .OpIn       (OpIn),
    .OpOut      (OpOut),
    .OpHalt     (OpHalt),
    .display_in (display_in),
    .cpu_en     (cpu_en),
    .in_data    (in_data),
    .disp_out   (disp_out),
    .status     (status)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Holds the button for n cycles, counting cpu_en pulses seen while the
  // state is wst. Optionally drops the CPU op once the CPU has advanced.
  // Then releases the button long enough for the debouncer to settle low.
  task automatic press_run(input int n, input logic [31:0] wst, input bit clr);
    pulses    = 0;
    first_idx = -1;
    in_at     = '0;
    disp_at   = '0;
    button_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      if (cpu_en && ({28'h0, status} == wst)) begin
        pulses++;
        if (first_idx < 0) begin
          first_idx = i;
          in_at     = 32'(in_data);
          disp_at   = 32'(disp_out);
        end
        if (clr) begin
          OpIn  = 1'b0;
          OpOut = 1'b0;
        end
      end
    end
    button_in = 1'b0;
    repeat (8) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    button_in  = 1'b0;
    switches   = '0;
    OpIn       = 1'b0;
    OpOut      = 1'b0;
    OpHalt     = 1'b0;
    display_in = '0;

    // Reset state
    repeat (3) step();
    check_eq("rst_status", 32'(status), S_RUN);
    check_eq("rst_cpu_en", 32'(cpu_en), 32'h1);
    check_eq("rst_disp", 32'(disp_out), BLANK);
    check_eq("rst_in_data", 32'(in_data), 32'h0);
    reset = 1'b0;
    repeat (5) step();

    // IN: stall, switch capture, single-step on press (latency 2+4+1 edges)
    OpIn     = 1'b1;
    switches = 18'h2A5A5;
    #1;
    check_eq("in_run_stall", 32'(cpu_en), 32'h0);
    step();
    check_eq("in_wait_status", 32'(status), S_WIN);
    check_eq("in_wait_cpu_en", 32'(cpu_en), 32'h0);
    press_run(12, S_WIN, 1'b1);
    check_eq("in_pulses", 32'(pulses), 32'h1);
    check_eq("in_press_latency", 32'(first_idx), 32'h6);
    check_eq("in_data_at_press", in_at, 32'h2A5A5);
    check_eq("in_after_status", 32'(status), S_RUN);
    check_eq("in_data_held", 32'(in_data), 32'h2A5A5);

    // OUT: display latch, press, blank
    OpOut      = 1'b1;
    display_in = 28'h0123456;
    #1;
    check_eq("out_run_stall", 32'(cpu_en), 32'h0);
    step();
    check_eq("out_wait_status", 32'(status), S_WOUT);
    check_eq("out_disp", 32'(disp_out), 32'h0123456);
    check_eq("out_wait_cpu_en", 32'(cpu_en), 32'h0);
    press_run(12, S_WOUT, 1'b1);
    check_eq("out_pulses", 32'(pulses), 32'h1);
    check_eq("out_press_latency", 32'(first_idx), 32'h6);
    check_eq("out_disp_at_press", disp_at, 32'h0123456);
    check_eq("out_disp_blank", 32'(disp_out), BLANK);
    check_eq("out_after_status", 32'(status), S_RUN);

    // Bounce 1-1-0-0-1-1-0-0 then held; OpIn stays high so a back-to-back
    // IN stalls again right after the single step.
    OpIn     = 1'b1;
    switches = 18'h00F0F;
    step();
    pulses    = 0;
    first_idx = -1;
    for (int i = 0; i < 22; i++) begin
      button_in = (i < 8) ? (((i / 2) % 2) == 0) : 1'b1;
      step();
      if (cpu_en) begin
        pulses++;
        if (first_idx < 0) first_idx = i;
      end
    end
    check_eq("bounce_pulses", 32'(pulses), 32'h1);
    check_eq("bounce_latency", 32'(first_idx), 32'd14);
    check_eq("bounce_restall", 32'(status), S_WIN);
    check_eq("bounce_in_data", 32'(in_data), 32'h00F0F);
    button_in = 1'b0;
    repeat (8) step();
    press_run(12, S_WIN, 1'b1);
    check_eq("bounce_exit_pulses", 32'(pulses), 32'h1);

    // Press landing in a RUN stall cycle is dropped
    button_in = 1'b1;
    repeat (7) step();
    OpIn = 1'b1;
    #1;
    check_eq("drop_run_cpu_en", 32'(cpu_en), 32'h0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (cpu_en) pulses++;
    end
    check_eq("drop_pulses", 32'(pulses), 32'h0);
    check_eq("drop_status", 32'(status), S_WIN);
    button_in = 1'b0;
    repeat (8) step();
    press_run(12, S_WIN, 1'b1);
    check_eq("drop_repress_pulses", 32'(pulses), 32'h1);

    // Reset in the middle of WAIT_OUT with the button held
    OpOut      = 1'b1;
    display_in = 28'hABCDEF0;
    step();
    check_eq("mid_disp", 32'(disp_out), 32'hABCDEF0);
    button_in = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    repeat (2) step();
    check_eq("mid_rst_status", 32'(status), S_RUN);
    check_eq("mid_rst_disp", 32'(disp_out), BLANK);
    reset = 1'b0;
    OpOut = 1'b0;
    OpIn  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (cpu_en) pulses++;
    end
    check_eq("mid_held_no_press", 32'(pulses), 32'h0);
    button_in = 1'b0;
    repeat (8) step();
    press_run(12, S_WIN, 1'b1);
    check_eq("mid_repress_pulses", 32'(pulses), 32'h1);

    // WAIT_OUT without a press
    OpOut      = 1'b1;
    display_in = 28'h5555555;
    step();
    check_eq("auto_wait_status", 32'(status), S_WOUT);
`ifdef CONTROLE_ES_AUTO_EN
    pulses    = 0;
    first_idx = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cpu_en && (status == 4'b0100)) begin
        pulses++;
        if (first_idx < 0) first_idx = i;
        OpOut = 1'b0;
      end
    end
    check_eq("auto_pulses", 32'(pulses), 32'h1);
    check_eq("auto_latency", 32'(first_idx), 32'h7);
    check_eq("auto_disp_blank", 32'(disp_out), BLANK);
    check_eq("auto_after_status", 32'(status), S_RUN);
`else
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (cpu_en) pulses++;
    end
    check_eq("noauto_no_pulse", 32'(pulses), 32'h0);
    check_eq("noauto_status", 32'(status), S_WOUT);
    press_run(12, S_WOUT, 1'b1);
    check_eq("noauto_press_pulses", 32'(pulses), 32'h1);
`endif

    // HALT wins over IN; terminal until reset
    OpHalt = 1'b1;
    OpIn   = 1'b1;
    #1;
    check_eq("halt_run_cpu_en", 32'(cpu_en), 32'h0);
    step();
    OpHalt = 1'b0;
    OpIn   = 1'b0;
    #1;
    check_eq("halt_status", 32'(status), S_HALT);
    check_eq("halt_cpu_en", 32'(cpu_en), 32'h0);
    press_run(12, S_HALT, 1'b0);
    check_eq("halt_press_ignored", 32'(pulses), 32'h0);
    check_eq("halt_stays", 32'(status), S_HALT);
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    #1;
    check_eq("halt_rst_status", 32'(status), S_RUN);
    check_eq("halt_rst_cpu_en", 32'(cpu_en), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
